// File: rtl/fm_discriminator_if.sv
// Sample-in / demodulated-out bundle for the FM discriminator.
// The master drives samples, the slave (the discriminator) returns results.
interface fm_discriminator_if #(
   parameter int unsigned WIDTH = 26,
   parameter int unsigned PW    = 16
);

   logic                    in_valid;
   logic signed [WIDTH-1:0] i_in;
   logic signed [WIDTH-1:0] q_in;
   logic                    ready;
   logic                    out_valid;
   logic signed [PW-1:0]    phase_out;
   logic signed [PW-1:0]    freq_out;

   modport master (
      output in_valid, i_in, q_in,
      input  ready, out_valid, phase_out, freq_out
   );

   modport slave (
      input  in_valid, i_in, q_in,
      output ready, out_valid, phase_out, freq_out
   );

endinterface

// File: rtl/fm_discriminator.sv
// FM discriminator: a vectoring CORDIC gives atan2(q, i); consecutive phases are
// differenced modulo 2*pi to give instantaneous frequency.
module fm_discriminator #(
   parameter int unsigned WIDTH = 26,
   parameter int unsigned PW    = 16,
   parameter int unsigned ITER  = 16
) (
   input  logic              clk,
   input  logic              reset,
   fm_discriminator_if.slave dsp_io
);

   // Fractional guard bits keep shift truncation far below one phase LSB for small inputs.
   localparam int unsigned GUARD = 8;
   localparam int unsigned DW    = WIDTH + 2 + GUARD;
   localparam int unsigned KW    = $clog2(ITER);
   localparam logic [PW-1:0] Quarter = PW'(1) << (PW - 2);

   typedef enum logic [1:0] {StIdle, StPre, StIterate, StDone} state_e;

   state_e               state_q, state_d;
   logic [KW-1:0]        k_q, k_d;
   logic signed [DW-1:0] x_q, x_d;
   logic signed [DW-1:0] y_q, y_d;
   logic signed [DW-1:0] x_sh, y_sh;
   logic [PW-1:0]        z_q, z_d;
   logic                 zero_q, zero_d;
   logic [PW-1:0]        phase_q, phase_d;
   logic [PW-1:0]        freq_q, freq_d;
   logic [PW-1:0]        prev_q, prev_d;
   logic                 first_q, first_d;

   // atan(2^-k) in units of 2*pi/2^16, rescaled to PW bits.
   function automatic logic [PW-1:0] atan_lut(input logic [KW-1:0] k);
      logic [15:0] a16;
      case (int'(k))
         0:       a16 = 16'd8192;
         1:       a16 = 16'd4836;
         2:       a16 = 16'd2555;
         3:       a16 = 16'd1297;
         4:       a16 = 16'd651;
         5:       a16 = 16'd326;
         6:       a16 = 16'd163;
         7:       a16 = 16'd81;
         8:       a16 = 16'd41;
         9:       a16 = 16'd20;
         10:      a16 = 16'd10;
         11:      a16 = 16'd5;
         12:      a16 = 16'd3;
         13:      a16 = 16'd1;
         14:      a16 = 16'd1;
         default: a16 = 16'd0;
      endcase
      if (PW >= 16) begin
         return PW'(a16) << (PW - 16);
      end
      return PW'((32'(a16) + (32'd1 << (15 - PW))) >> (16 - PW));
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         k_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         zero_q  <= 1'b0;
         phase_q <= '0;
         freq_q  <= '0;
         prev_q  <= '0;
         first_q <= 1'b1;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         zero_q  <= zero_d;
         phase_q <= phase_d;
         freq_q  <= freq_d;
         prev_q  <= prev_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (dsp_io.in_valid) state_d = StPre;
         StPre:     state_d = StIterate;
         StIterate: if (k_q == KW'(ITER - 1)) state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      k_d     = k_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      zero_d  = zero_q;
      phase_d = phase_q;
      freq_d  = freq_q;
      prev_d  = prev_q;
      first_d = first_q;
      x_sh    = x_q >>> k_q;
      y_sh    = y_q >>> k_q;
      unique case (state_q)
         StIdle: begin
            if (dsp_io.in_valid) begin
               x_d    = {{2{dsp_io.i_in[WIDTH-1]}}, dsp_io.i_in, {GUARD{1'b0}}};
               y_d    = {{2{dsp_io.q_in[WIDTH-1]}}, dsp_io.q_in, {GUARD{1'b0}}};
               zero_d = (dsp_io.i_in == '0) && (dsp_io.q_in == '0);
               k_d    = '0;
            end
         end
         StPre: begin
            // Fold left half-plane into the right so the CORDIC converges.
            if (!x_q[DW-1]) begin
               z_d = '0;
            end else if (!y_q[DW-1]) begin
               x_d = y_q;
               y_d = -x_q;
               z_d = Quarter;
            end else begin
               x_d = -y_q;
               y_d = x_q;
               z_d = -Quarter;
            end
         end
         StIterate: begin
            if (!y_q[DW-1]) begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + atan_lut(k_q);
            end else begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - atan_lut(k_q);
            end
            k_d = k_q + 1'b1;
            // Results land with the last micro-rotation so they are stable during StDone.
            if (k_q == KW'(ITER - 1)) begin
               if (zero_q) begin
                  phase_d = prev_q;
                  freq_d  = '0;
               end else begin
                  phase_d = z_d;
                  freq_d  = first_q ? '0 : z_d - prev_q;
                  prev_d  = z_d;
                  first_d = 1'b0;
               end
            end
         end
         StDone: begin
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      dsp_io.ready     = (state_q == StIdle);
      dsp_io.out_valid = (state_q == StDone);
      dsp_io.phase_out = phase_q;
      dsp_io.freq_out  = freq_q;
   end

endmodule

// File: tb/tb_fm_discriminator.sv
// Scoreboard bench for fm_discriminator: directed I/Q vectors with hand-derived
// phase/frequency expectations, checked by an independent output monitor.
module tb_fm_discriminator;

   localparam int unsigned WIDTH = 26;
   localparam int unsigned PW    = 16;
   localparam int unsigned ITER  = 16;
   localparam real TwoPi     = 6.283185307179586;
   localparam real FullScale = 33554431.0;

   typedef struct {
      logic [PW-1:0] phase;
      int            ptol;
      logic [PW-1:0] freq;
      int            ftol;
      int            acc_cyc;
      int            tag;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   tag_n = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fm_discriminator_if #(.WIDTH(WIDTH), .PW(PW)) dut_if ();

   fm_discriminator #(.WIDTH(WIDTH), .PW(PW), .ITER(ITER)) dut (
      .clk    (clk),
      .reset  (reset),
      .dsp_io (dut_if)
   );

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_tol(input string name, input int tag, input logic [PW-1:0] act,
                            input logic [PW-1:0] exp, input int tol);
      logic signed [PW-1:0] d;
      int ad;
      d  = act - exp;
      ad = (d < 0) ? -int'(d) : int'(d);
      n_cmp++;
      if (ad > tol) begin
         n_bad++;
         $display("FAIL %s sample %0d: got 0x%04h, expected 0x%04h +/-%0d",
                  name, tag, act, exp, tol);
      end
   endtask

   always @(negedge clk) begin
      if (dut_if.out_valid) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, expected none", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            check_tol("phase_out", mon_e.tag, dut_if.phase_out, mon_e.phase, mon_e.ptol);
            check_tol("freq_out", mon_e.tag, dut_if.freq_out, mon_e.freq, mon_e.ftol);
            check_int("latency", cyc - mon_e.acc_cyc, ITER + 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic int rnd(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
   endfunction

   task automatic phasor(input real amp, input int ang, output logic signed [WIDTH-1:0] i,
                         output logic signed [WIDTH-1:0] q);
      real a;
      a = TwoPi * real'(ang & 16'hFFFF) / 65536.0;
      i = WIDTH'(rnd(amp * $cos(a)));
      q = WIDTH'(rnd(amp * $sin(a)));
   endtask

   task automatic push_exp(input logic [PW-1:0] ep, input int pt, input logic [PW-1:0] ef,
                           input int ft);
      exp_t e;
      e.phase   = ep;
      e.ptol    = pt;
      e.freq    = ef;
      e.ftol    = ft;
      e.acc_cyc = cyc;
      e.tag     = tag_n;
      tag_n++;
      sb_q.push_back(e);
   endtask

   task automatic send(input logic signed [WIDTH-1:0] i, input logic signed [WIDTH-1:0] q,
                       input logic [PW-1:0] ep, input int pt, input logic [PW-1:0] ef,
                       input int ft, input bit push);
      int w;
      w = 0;
      while (!dut_if.ready && w < 100) begin
         tick();
         w++;
      end
      if (!dut_if.ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: got ready=0 after %0d cycles, expected 1", w);
      end
      dut_if.in_valid = 1'b1;
      dut_if.i_in     = i;
      dut_if.q_in     = q;
      tick();
      if (push) push_exp(ep, pt, ef, ft);
      dut_if.in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish by time limit, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic signed [WIDTH-1:0] ti, tq;
      logic [PW-1:0]           ef;
      int                      ang, ft, lows;

      reset           = 1'b1;
      dut_if.in_valid = 1'b1;
      dut_if.i_in     = WIDTH'(777);
      dut_if.q_in     = WIDTH'(-333);
      repeat (3) tick();
      dut_if.in_valid = 1'b0;
      reset           = 1'b0;
      check_int("rst_ready", int'(dut_if.ready), 1);
      check_int("rst_out_valid", int'(dut_if.out_valid), 0);
      check_int("rst_phase", int'(dut_if.phase_out), 0);
      check_int("rst_freq", int'(dut_if.freq_out), 0);

      // Axis and diagonal vectors.
      send(26'sd1000, 26'sd0, 16'h0000, 4, 16'h0000, 0, 1);
      repeat (20) tick();
      send(26'sd0, 26'sd1000, 16'h4000, 4, 16'h4000, 8, 1);
      repeat (20) tick();
      send(-26'sd1000, 26'sd0, 16'h8000, 4, 16'h4000, 8, 1);
      repeat (20) tick();
      send(26'sd0, -26'sd1000, 16'hC000, 4, 16'h4000, 8, 1);
      repeat (20) tick();
      send(26'sd1000, 26'sd1000, 16'h2000, 4, 16'h6000, 8, 1);
      repeat (20) tick();

      // Full-scale rotating phasor, forward then backward.
      do_reset();
      ang = 0;
      for (int n = 0; n < 40; n++) begin
         if (n > 0) ang = (n <= 31) ? ang + 4096 : ang - 2048;
         phasor(FullScale, ang, ti, tq);
         ef = (n == 0) ? 16'h0000 : ((n <= 31) ? 16'h1000 : 16'hF800);
         ft = (n == 0) ? 0 : 8;
         send(ti, tq, 16'(ang), 4, ef, ft, 1);
      end
      repeat (20) tick();

      // Phase steps across +/-pi.
      do_reset();
      phasor(1048576.0, 32'h7F00, ti, tq);
      send(ti, tq, 16'h7F00, 4, 16'h0000, 0, 1);
      phasor(1048576.0, 32'h8100, ti, tq);
      send(ti, tq, 16'h8100, 4, 16'h0200, 8, 1);
      phasor(1048576.0, 32'h7F00, ti, tq);
      send(ti, tq, 16'h7F00, 4, 16'hFE00, 8, 1);
      repeat (20) tick();

      // in_valid held high: only every 19th sample is taken.
      lows = 0;
      for (int t = 0; t < 57; t++) begin
         dut_if.in_valid = 1'b1;
         if (t % 19 == 0) begin
            phasor(1048576.0, 32'h1000 + (t / 19) * 32'h2000, ti, tq);
         end else begin
            ti = -26'sd700;
            tq = 26'sd123;
         end
         dut_if.i_in = ti;
         dut_if.q_in = tq;
         if (!dut_if.ready) lows++;
         tick();
         if (t == 0)  push_exp(16'h1000, 4, 16'h9100, 8);
         if (t == 19) push_exp(16'h3000, 4, 16'h2000, 8);
         if (t == 38) push_exp(16'h5000, 4, 16'h2000, 8);
      end
      dut_if.in_valid = 1'b0;
      check_int("busy_ready_low_cycles", lows, 54);
      repeat (25) tick();

      // Reset during the CORDIC iterations aborts the sample.
      send(26'sd1000, 26'sd300, 16'h0000, 0, 16'h0000, 0, 0);
      repeat (6) tick();
      do_reset();
      check_int("abort_out_valid", int'(dut_if.out_valid), 0);
      check_int("abort_phase", int'(dut_if.phase_out), 0);
      check_int("abort_freq", int'(dut_if.freq_out), 0);
      check_int("abort_ready", int'(dut_if.ready), 1);
      repeat (30) tick();

      // Zero vectors repeat the last phase and leave history untouched.
      send(26'sd0, 26'sd0, 16'h0000, 0, 16'h0000, 0, 1);
      send(26'sd0, 26'sd500, 16'h4000, 4, 16'h0000, 0, 1);
      send(26'sd0, 26'sd0, 16'h4000, 4, 16'h0000, 0, 1);
      send(-26'sd500, 26'sd0, 16'h8000, 4, 16'h4000, 8, 1);
      repeat (30) tick();

      check_int("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
